// File: rtl/if_fetch_pkg.sv
// Shared pipeline constants and types for the instruction-fetch stage.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package if_fetch_pkg;

  // Value placed on pc/pc4/inst when no instruction is being delivered.
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_obuf.sv
// One-entry output buffer holding the instruction presented to decode.
// Latency: a load is visible on the outputs the cycle after the load edge.
// Backpressure: entry is held until consumed; clear wins over load, load over consume.
module if_obuf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  // Next-state: a redirect empties the buffer, a new fetch replaces it, a consume empties it.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d      = 1'b1;
      entry_d.pc   = load_pc_i;
      entry_d.inst = load_inst_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers; reset leaves the buffer empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = entry_q.pc;
  assign inst_o  = entry_q.inst;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues word requests to imem and feeds one instruction per cycle to decode.
// Latency: an acked word appears on pc_o/inst_o one cycle after its ack; zero-wait memory sustains 1/cycle.
// Backpressure: stall_i holds the buffered instruction and suppresses new requests while the buffer is full.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o,
  output logic [31:0] fetch_cnt_o
);

  // RUN: normal fetching. DROP: a request was in flight when a redirect hit;
  // keep it asserted on the old address until memory answers, then throw the data away.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] cnt_q, cnt_d;

  logic        obuf_valid;
  logic [31:0] obuf_pc;
  logic [31:0] obuf_inst;
  logic        obuf_load;
  logic        obuf_consume;
  logic        obuf_clear;
  logic        out_vld;

  // Request generation plus next-state for fetch PC, drop address, counter and buffer controls.
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    drop_addr_d  = drop_addr_q;
    cnt_d        = cnt_q;
    obuf_load    = 1'b0;
    obuf_consume = 1'b0;
    obuf_clear   = 1'b0;
    imem_req_o   = 1'b0;
    imem_addr_o  = fpc_q;

    if (state_q == S_RUN) begin
      // A full buffer that is not draining cannot accept another word.
      imem_req_o  = ~obuf_valid | ~stall_i;
      imem_addr_o = fpc_q;
    end else begin
      imem_req_o  = 1'b1;
      imem_addr_o = drop_addr_q;
    end
    // Memory shares this reset, so nothing may be requested while it is held.
    if (!rst_n) begin
      imem_req_o = 1'b0;
    end

    if (redirect_i) begin
      // Redirect outranks stall and ack: nothing is consumed and same-cycle data is lost.
      fpc_d      = word_align(redirect_pc_i);
      obuf_clear = 1'b1;
      if (state_q == S_RUN) begin
        if (imem_req_o && !imem_ack_i) begin
          state_d     = S_DROP;
          drop_addr_d = fpc_q;
        end
      end else if (imem_ack_i) begin
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      obuf_consume = obuf_valid & ~stall_i;
      if (imem_req_o && imem_ack_i) begin
        obuf_load = 1'b1;
        fpc_d     = fpc_q + 32'd4;
      end
      if (obuf_consume) begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (imem_ack_i) begin
      // Stale response to the abandoned address: discard and resume at fpc.
      state_d = S_RUN;
    end
  end

  // State registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      fpc_q       <= RESET_PC;
      drop_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  if_obuf u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (obuf_clear),
    .load_i      (obuf_load),
    .consume_i   (obuf_consume),
    .load_pc_i   (fpc_q),
    .load_inst_i (imem_rdata_i),
    .valid_o     (obuf_valid),
    .pc_o        (obuf_pc),
    .inst_o      (obuf_inst)
  );

  // Outputs read as a bubble whenever nothing is buffered or reset is asserted.
  assign out_vld     = obuf_valid & rst_n;
  assign pc_o        = out_vld ? obuf_pc : BUBBLE;
  assign pc4_o       = out_vld ? (obuf_pc + 32'd4) : BUBBLE;
  assign inst_o      = out_vld ? obuf_inst : BUBBLE;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed vector table followed by randomized traffic
// against a stream-level reference model of the fetch stage.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic [31:0] inst_o;
  logic [31:0] fetch_cnt_o;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .inst_o        (inst_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents used in random traffic; never zero, so a nonzero inst_o marks a delivery.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input int rst, input int stl, input int rdr, input logic [31:0] rpc,
                              input int ack, input logic [31:0] rdat, input int e_req,
                              input logic [31:0] e_addr, input int e_vld, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = (rst != 0);     v.stl = (stl != 0);   v.rdr = (rdr != 0);   v.rpc = rpc;
    v.ack = (ack != 0);     v.rdat = rdat;        v.e_req = (e_req != 0);
    v.e_addr = e_addr;      v.e_vld = (e_vld != 0);
    v.e_pc = e_pc;          v.e_inst = e_inst;    v.e_cnt = e_cnt;
    return v;
  endfunction

  localparam int NVEC = 28;
  vec_t tbl [NVEC];

  // Random-phase model state
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        hold_prev;
  logic [31:0] prev_addr;
  logic        bubble_due;
  int          wait_cnt;
  int          lat;
  logic        valid;

  initial begin
    //          rst stl rdr rpc            ack rdat           req addr           vld pc             inst           cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          0);
    tbl[1]  = mk(0, 1, 1, 32'h40,         1, 32'h99,         0, 32'h0,          0, 32'h0,          32'h0,          0);
    tbl[2]  = mk(1, 0, 0, 32'h0,          1, 32'hA000_0000,  1, 32'h0,          1, 32'h0,          32'hA000_0000,  0);
    tbl[3]  = mk(1, 0, 0, 32'h0,          1, 32'hA000_0001,  1, 32'h4,          1, 32'h4,          32'hA000_0001,  1);
    tbl[4]  = mk(1, 0, 0, 32'h0,          1, 32'hA000_0002,  1, 32'h8,          1, 32'h8,          32'hA000_0002,  2);
    tbl[5]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h8,          32'hA000_0002,  2);
    tbl[6]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h8,          32'hA000_0002,  2);
    tbl[7]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h8,          32'hA000_0002,  2);
    tbl[8]  = mk(1, 0, 0, 32'h0,          1, 32'hA000_0003,  1, 32'hC,          1, 32'hC,          32'hA000_0003,  3);
    tbl[9]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         0, 32'h0,          32'h0,          4);
    tbl[10] = mk(1, 0, 1, 32'h100,        0, 32'h0,          1, 32'h10,         0, 32'h0,          32'h0,          4);
    tbl[11] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         0, 32'h0,          32'h0,          4);
    tbl[12] = mk(1, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  1, 32'h10,         0, 32'h0,          32'h0,          4);
    tbl[13] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0004,  1, 32'h100,        1, 32'h100,        32'hA000_0004,  4);
    tbl[14] = mk(1, 1, 1, 32'h203,        1, 32'hBAD0_0BAD,  0, 32'h0,          0, 32'h0,          32'h0,          4);
    tbl[15] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0005,  1, 32'h200,        1, 32'h200,        32'hA000_0005,  4);
    tbl[16] = mk(1, 0, 1, 32'hFFFF_FFFF,  1, 32'hBAD1_0000,  1, 32'h204,        0, 32'h0,          32'h0,          4);
    tbl[17] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0006,  1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  32'hA000_0006,  4);
    tbl[18] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0007,  1, 32'h0,          1, 32'h0,          32'hA000_0007,  5);
    tbl[19] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          6);
    tbl[20] = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          0);
    tbl[21] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,          0);
    tbl[22] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0008,  1, 32'h0,          1, 32'h0,          32'hA000_0008,  0);
    tbl[23] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          1);
    tbl[24] = mk(1, 0, 1, 32'h300,        0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          1);
    tbl[25] = mk(1, 0, 1, 32'h400,        0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h0,          1);
    tbl[26] = mk(1, 0, 0, 32'h0,          1, 32'h5555_5555,  1, 32'h4,          0, 32'h0,          32'h0,          1);
    tbl[27] = mk(1, 0, 0, 32'h0,          1, 32'hA000_0009,  1, 32'h400,        1, 32'h400,        32'hA000_0009,  1);

    // Directed table: check request before the edge, delivered instruction after it.
    for (int i = 0; i < NVEC; i++) begin
      rst_n         = tbl[i].rst;
      stall_i       = tbl[i].stl;
      redirect_i    = tbl[i].rdr;
      redirect_pc_i = tbl[i].rpc;
      imem_ack_i    = tbl[i].ack;
      imem_rdata_i  = tbl[i].rdat;
      #1;
      chkb($sformatf("v%0d_req", i), imem_req_o, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc_o, tbl[i].e_vld ? tbl[i].e_pc : 32'h0);
      chk($sformatf("v%0d_pc4", i), pc4_o, tbl[i].e_vld ? tbl[i].e_pc + 32'd4 : 32'h0);
      chk($sformatf("v%0d_inst", i), inst_o, tbl[i].e_vld ? tbl[i].e_inst : 32'h0);
      chk($sformatf("v%0d_cnt", i), fetch_cnt_o, tbl[i].e_cnt);
    end

    // Random traffic: restart from reset, then compare against the delivery-stream model.
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    @(posedge clk);
    #1;
    exp_pc = 32'h0; exp_cnt = 32'h0; hold_prev = 1'b0; prev_addr = '0;
    bubble_due = 1'b1; wait_cnt = 0; lat = $urandom_range(0, 3);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      stall_i    = ($urandom_range(0, 9) < 3);
      redirect_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc_i = $urandom & 32'h0000_0FFF;
      imem_ack_i   = 1'b0;
      imem_rdata_i = $urandom;
      #1;
      valid = (inst_o != 32'h0);
      if (!rst_n) begin
        chkb("rst_req", imem_req_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
      end else begin
        // The request may only be withheld while a delivered instruction is stalled.
        chkb("req_rule", imem_req_o, !(valid && stall_i));
        if (valid) chk("pc4_rel", pc4_o, pc_o + 32'd4);
        else begin
          chk("bub_pc", pc_o, 32'h0);
          chk("bub_pc4", pc4_o, 32'h0);
        end
        if (hold_prev) begin
          chkb("hold_req", imem_req_o, 1'b1);
          chk("hold_addr", imem_addr_o, prev_addr);
        end
        if (bubble_due) chk("post_redir_bubble", inst_o, 32'h0);
        if (valid && !stall_i && !redirect_i) begin
          chk("stream_pc", pc_o, exp_pc);
          chk("stream_inst", inst_o, mem_word(exp_pc));
          exp_pc  = exp_pc + 32'd4;
          exp_cnt = exp_cnt + 32'd1;
        end
      end
      // Memory answers a request once its drawn latency has elapsed.
      if (rst_n && imem_req_o && wait_cnt >= lat) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
      end
      hold_prev  = rst_n && imem_req_o && !imem_ack_i;
      prev_addr  = imem_addr_o;
      bubble_due = !rst_n || redirect_i;
      if (!rst_n || !imem_req_o || imem_ack_i) begin
        wait_cnt = 0;
        lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
      if (!rst_n) begin
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
      end else if (redirect_i) begin
        exp_pc = {redirect_pc_i[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      chk("cnt", fetch_cnt_o, exp_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
